// File: rtl/strobe_dec_pkg.sv
// Shared types and constants for the strobe_decoder block.
package strobe_dec_pkg;

    // FSM states; IDLE must encode as zero so busy is simply state != IDLE
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        PULSE = 2'd2
    } state_t;

    // Output mode selector values sampled at accept
    localparam logic MODE_LEVEL = 1'b0;
    localparam logic MODE_PULSE = 1'b1;

    // Width of the optional saturating reject counter
    localparam int ERR_CNT_W = 16;

endpackage

// File: rtl/strobe_decoder_onehot_decode.sv
// Combinational SEL_W -> NUM_OUT one-hot decoder with range flag.
module onehot_decode #(
    parameter int SEL_W   = 3,
    parameter int NUM_OUT = 2**SEL_W
) (
    input  logic [SEL_W-1:0]   sel,
    output logic [NUM_OUT-1:0] onehot,
    output logic               in_range
);

    // One comparator per output; a code >= NUM_OUT matches none of them
    for (genvar i = 0; i < NUM_OUT; i++) begin : g_dec
        assign onehot[i] = (sel == SEL_W'(i));
    end

    // Out-of-range codes are exactly those that decode to all zeros
    assign in_range = |onehot;

endmodule

// File: rtl/strobe_decoder.sv
// Registered one-hot strobe decoder with level and pulse output modes.
// Optional build macro STROBE_DEC_ERR_CNT_EN adds a saturating 16-bit
// count of rejected codes on port err_cnt.
import strobe_dec_pkg::*;

module strobe_decoder #(
    parameter int SEL_W   = 3,
    parameter int NUM_OUT = 2**SEL_W,
    parameter int LEN_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               mode,
    input  logic [LEN_W-1:0]   pulse_len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   sel,
    output logic [NUM_OUT-1:0] out,
    output logic               busy,
    output logic               err
`ifdef STROBE_DEC_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [NUM_OUT-1:0] r_out;
    logic [NUM_OUT-1:0] w_out_nxt;
    logic               r_err;
    logic               w_err_nxt;
    logic [LEN_W-1:0]   r_cnt;
    logic [LEN_W-1:0]   w_cnt_nxt;

    logic [NUM_OUT-1:0] w_onehot;
    logic               w_in_range;
    logic               w_accept;
    logic [LEN_W-1:0]   w_len_eff;

    onehot_decode #(
        .SEL_W   (SEL_W),
        .NUM_OUT (NUM_OUT)
    ) u_dec (
        .sel      (sel),
        .onehot   (w_onehot),
        .in_range (w_in_range)
    );

    assign in_ready  = !rst && !clr && (r_state != PULSE);
    assign w_accept  = in_valid && in_ready;
    // A zero length still produces a single-cycle strobe
    assign w_len_eff = (pulse_len == '0) ? LEN_W'(1) : pulse_len;

    // Next-state, next-output and pulse counter; clr beats any accept
    always_comb begin
        w_state_nxt = r_state;
        w_out_nxt   = r_out;
        w_err_nxt   = 1'b0;
        w_cnt_nxt   = r_cnt;
        if (clr) begin
            w_state_nxt = IDLE;
            w_out_nxt   = '0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE, HOLD: begin
                    if (w_accept) begin
                        if (w_in_range) begin
                            w_out_nxt = w_onehot;
                            if (mode == MODE_PULSE) begin
                                w_state_nxt = PULSE;
                                w_cnt_nxt   = w_len_eff;
                            end else begin
                                w_state_nxt = HOLD;
                            end
                        end else begin
                            w_state_nxt = IDLE;
                            w_out_nxt   = '0;
                            w_err_nxt   = 1'b1;
                        end
                    end
                end
                PULSE: begin
                    // Count of 1 means this is the last high cycle
                    if (r_cnt <= LEN_W'(1)) begin
                        w_state_nxt = IDLE;
                        w_out_nxt   = '0;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - LEN_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_out_nxt   = '0;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State, output, error flag and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_out   <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_out   <= w_out_nxt;
            r_err   <= w_err_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign out  = r_out;
    assign busy = (r_state != IDLE);
    assign err  = r_err;

`ifdef STROBE_DEC_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] r_err_cnt;

    // Saturating reject count, bumped on the same edge that raises err
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (w_err_nxt && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_strobe_decoder.sv
// Directed bench for strobe_decoder: a full-range instance (8 outputs)
// driven from a vector table plus hand sequences, and a 6-output instance
// for out-of-range rejects.
module tb_strobe_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: SEL_W=3, NUM_OUT=8
    logic       a_rst, a_clr, a_mode, a_valid, a_ready, a_busy, a_err;
    logic [7:0] a_len;
    logic [2:0] a_sel;
    logic [7:0] a_out;
    // Instance B: SEL_W=3, NUM_OUT=6
    logic       b_rst, b_clr, b_mode, b_valid, b_ready, b_busy, b_err;
    logic [7:0] b_len;
    logic [2:0] b_sel;
    logic [5:0] b_out;
`ifdef STROBE_DEC_ERR_CNT_EN
    logic [15:0] a_err_cnt, b_err_cnt;
`endif

    strobe_decoder #(.SEL_W(3), .NUM_OUT(8), .LEN_W(8)) dut_a (
        .clk(clk), .rst(a_rst), .clr(a_clr), .mode(a_mode), .pulse_len(a_len),
        .in_valid(a_valid), .in_ready(a_ready), .sel(a_sel), .out(a_out),
        .busy(a_busy), .err(a_err)
`ifdef STROBE_DEC_ERR_CNT_EN
        , .err_cnt(a_err_cnt)
`endif
    );

    strobe_decoder #(.SEL_W(3), .NUM_OUT(6), .LEN_W(8)) dut_b (
        .clk(clk), .rst(b_rst), .clr(b_clr), .mode(b_mode), .pulse_len(b_len),
        .in_valid(b_valid), .in_ready(b_ready), .sel(b_sel), .out(b_out),
        .busy(b_busy), .err(b_err)
`ifdef STROBE_DEC_ERR_CNT_EN
        , .err_cnt(b_err_cnt)
`endif
    );

    typedef struct {
        logic       clr;
        logic       mode;
        logic [7:0] len;
        logic       vld;
        logic [2:0] sel;
        logic       e_rdy;   // in_ready with these inputs applied
        logic [7:0] e_out;   // after the edge
        logic       e_busy;
        logic       e_err;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic c, input logic m, input logic [7:0] l,
                                input logic v, input logic [2:0] s, input logic r,
                                input logic [7:0] o, input logic b, input logic e);
        vec_t t;
        t.clr = c; t.mode = m; t.len = l; t.vld = v; t.sel = s;
        t.e_rdy = r; t.e_out = o; t.e_busy = b; t.e_err = e;
        return t;
    endfunction

    initial begin
        a_rst = 1; a_clr = 0; a_mode = 0; a_len = 0; a_valid = 0; a_sel = 0;
        b_rst = 1; b_clr = 0; b_mode = 0; b_len = 0; b_valid = 0; b_sel = 0;

        // Level switching: every code back to back, no zero cycles
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0, 0, 8'd0, 1, 3'(i), 1, 8'(1 << i), 1, 0));
        // Pulse and gap: len 3, sel 2, valid held; starts from HOLD
        for (int r = 0; r < 2; r++) begin
            tbl.push_back(mk(0, 1, 8'd3, 1, 3'd2, 1, 8'h04, 1, 0));
            tbl.push_back(mk(0, 1, 8'd3, 1, 3'd2, 0, 8'h04, 1, 0));
            tbl.push_back(mk(0, 1, 8'd3, 1, 3'd2, 0, 8'h04, 1, 0));
            tbl.push_back(mk(0, 1, 8'd3, 1, 3'd2, 0, 8'h00, 0, 0));
        end
        tbl.push_back(mk(0, 0, 8'd0, 0, 3'd0, 1, 8'h00, 0, 0));
        // Zero length pulse: one cycle high
        tbl.push_back(mk(0, 1, 8'd0, 1, 3'd5, 1, 8'h20, 1, 0));
        tbl.push_back(mk(0, 0, 8'd0, 0, 3'd0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 8'd0, 0, 3'd0, 1, 8'h00, 0, 0));
        // Clear priority over a request during HOLD
        tbl.push_back(mk(0, 0, 8'd0, 1, 3'd1, 1, 8'h02, 1, 0));
        tbl.push_back(mk(1, 0, 8'd0, 1, 3'd4, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 8'd0, 0, 3'd4, 1, 8'h00, 0, 0));
        // Clear mid-pulse discards the remaining count
        tbl.push_back(mk(0, 1, 8'd9, 1, 3'd3, 1, 8'h08, 1, 0));
        tbl.push_back(mk(1, 1, 8'd9, 0, 3'd3, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 8'd0, 0, 3'd0, 1, 8'h00, 0, 0));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", 32'(a_out), 0);
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_err", 32'(a_err), 0);
        chk("rst_ready", 32'(a_ready), 0);
        @(negedge clk);
        a_rst = 0; b_rst = 0;
        #1;
        chk("post_rst_ready", 32'(a_ready), 1);

        // Table
        foreach (tbl[i]) begin
            @(negedge clk);
            a_clr = tbl[i].clr; a_mode = tbl[i].mode; a_len = tbl[i].len;
            a_valid = tbl[i].vld; a_sel = tbl[i].sel;
            #1;
            chk($sformatf("tbl_ready[%0d]", i), 32'(a_ready), 32'(tbl[i].e_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("tbl_out[%0d]", i), 32'(a_out), 32'(tbl[i].e_out));
            chk($sformatf("tbl_busy[%0d]", i), 32'(a_busy), 32'(tbl[i].e_busy));
            chk($sformatf("tbl_err[%0d]", i), 32'(a_err), 32'(tbl[i].e_err));
        end

        // Reset mid-pulse: len 5, sel 6, rst in cycle 3
        @(negedge clk);
        a_clr = 0; a_mode = 1; a_len = 8'd5; a_sel = 3'd6; a_valid = 1;
        @(posedge clk); #1;
        chk("rmp_c1", 32'(a_out), 32'h40);
        @(negedge clk);
        a_valid = 0;
        @(posedge clk); #1;
        chk("rmp_c2", 32'(a_out), 32'h40);
        @(posedge clk); #1;
        chk("rmp_c3", 32'(a_out), 32'h40);
        @(negedge clk);
        a_rst = 1;
        #1;
        chk("rmp_ready_in_rst", 32'(a_ready), 0);
        @(posedge clk); #1;
        chk("rmp_out", 32'(a_out), 0);
        chk("rmp_busy", 32'(a_busy), 0);
        chk("rmp_err", 32'(a_err), 0);
        chk("rmp_ready_held", 32'(a_ready), 0);
        @(negedge clk);
        a_rst = 0;

        // Out of range on the 6-output instance, from HOLD then from IDLE
        @(negedge clk);
        b_mode = 0; b_sel = 3'd1; b_valid = 1;
        @(posedge clk); #1;
        chk("oor_hold_out", 32'(b_out), 32'h02);
        @(negedge clk);
        b_sel = 3'd7;
        #1;
        chk("oor_ready", 32'(b_ready), 1);
        @(posedge clk); #1;
        chk("oor_out", 32'(b_out), 0);
        chk("oor_err", 32'(b_err), 1);
        chk("oor_busy", 32'(b_busy), 0);
`ifdef STROBE_DEC_ERR_CNT_EN
        chk("oor_cnt1", 32'(b_err_cnt), 1);
`endif
        @(negedge clk);
        b_valid = 0;
        @(posedge clk); #1;
        chk("oor_err_drop", 32'(b_err), 0);
        @(negedge clk);
        b_sel = 3'd6; b_valid = 1;
        @(posedge clk); #1;
        chk("oor_idle_err", 32'(b_err), 1);
        chk("oor_idle_out", 32'(b_out), 0);
        @(negedge clk);
        b_sel = 3'd5; b_mode = 1; b_len = 8'd2;
        @(posedge clk); #1;
        chk("top_code_out", 32'(b_out), 32'h20);
        chk("top_code_err", 32'(b_err), 0);
`ifdef STROBE_DEC_ERR_CNT_EN
        chk("oor_cnt2", 32'(b_err_cnt), 2);
        chk("a_cnt_zero", 32'(a_err_cnt), 0);
`endif
        @(negedge clk);
        b_valid = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
